spi_read_sched: RTL

SPI_READ_SCHED -- requirements
Module: spi_read_sched

---
 rtl/spi_read_sched_pkg.sv | 8 +
 rtl/spi_read_sched_if.sv | 21 ++
 rtl/spi_read_sched_shift_engine.sv | 63 ++++++
 rtl/spi_read_sched.sv | 114 +++++++++++
 4 files changed

// File: rtl/spi_read_sched_pkg.sv
// Shared types and default sizing for the SPI read scheduler.
package spi_read_sched_pkg;
  localparam int NBIT_DEF = 32;
  localparam int ABIT_DEF = 8;
  localparam int DIV_DEF  = 5;

  typedef enum logic [2:0] {IDLE, SETUP, ADDR, DATA, HOLD, GAP} state_t;
endpackage

// File: rtl/spi_read_sched_if.sv
// Requester handshake plus SPI pins of the read scheduler.
// slave: the scheduler side; master: requesters and the SPI device.
interface spi_read_sched_if
  import spi_read_sched_pkg::*;
#(
  parameter int NBIT = NBIT_DEF,
  parameter int ABIT = ABIT_DEF
);
  logic [1:0]           req;
  logic [1:0][ABIT-1:0] adr;
  logic [1:0]           ack;
  logic [NBIT-1:0]      rdata;
  logic                 busy;
  logic                 sclk;
  logic                 mosi;
  logic                 cs;
  logic                 miso;

  modport slave  (input req, adr, miso, output ack, rdata, busy, sclk, mosi, cs);
  modport master (output req, adr, miso, input ack, rdata, busy, sclk, mosi, cs);
endinterface

// File: rtl/spi_read_sched_shift_engine.sv
// SPI bit engine: W bits of DIV-low/DIV-high sclk, mosi shifted MSB first,
// miso captured on each sclk rise; the last RW captured bits form din.
module spi_shift_engine #(
  parameter int W   = 40,
  parameter int RW  = 32,
  parameter int DIV = 5,
  parameter int BW  = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          en,
  input  logic [W-1:0]  dout,
  input  logic          miso,
  output logic          sclk,
  output logic          mosi,
  output logic          bit_end,
  output logic          done,
  output logic [BW-1:0] bit_idx,
  output logic [RW-1:0] din
);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic          phase;
  logic          div_end;
  logic [W-1:0]  sh_out;

  assign div_end = (div_cnt == DW'(DIV - 1));
  assign sclk    = en & phase;
  assign mosi    = sh_out[W-1];
  assign bit_end = en & phase & div_end;
  assign done    = bit_end & (bit_idx == BW'(W - 1));

  // half-period timer; capture on the rising edge, shift out on the falling edge
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      phase   <= 1'b0;
      bit_idx <= '0;
      sh_out  <= '0;
      din     <= '0;
    end else if (load) begin
      div_cnt <= '0;
      phase   <= 1'b0;
      bit_idx <= '0;
      sh_out  <= dout;
    end else if (en) begin
      if (div_end) begin
        div_cnt <= '0;
        phase   <= ~phase;
        if (!phase) begin
          din <= {din[RW-2:0], miso};
        end else begin
          sh_out  <= {sh_out[W-2:0], 1'b1};
          bit_idx <= bit_idx + BW'(1);
        end
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end
endmodule

// File: rtl/spi_read_sched.sv
// Two-requester SPI read scheduler: arbitrate, send address, read one word,
// ack the requester as cs rises, then enforce a cs-high gap.
// Optional macro SPI_READ_SCHED_RR_EN: round-robin tie break (default fixed,
// requester 0 wins).
module spi_read_sched
  import spi_read_sched_pkg::*;
#(
  parameter int NBIT     = NBIT_DEF,
  parameter int ABIT     = ABIT_DEF,
  parameter int DIV      = DIV_DEF,
  parameter int CS_SETUP = 10,
  parameter int CS_HOLD  = 10,
  parameter int CS_GAP   = 4
) (
  input logic             clk,
  input logic             rst,
  spi_read_sched_if.slave bus
);
  localparam int W  = ABIT + NBIT;
  localparam int BW = $clog2(W + 1);

  state_t          state, nxt;
  logic [15:0]     cnt;
  logic            last;      // current / most recent grant
  logic            gnt;
  logic            load;
  logic            shifting;
  logic            eng_sclk, eng_mosi, bit_end, done;
  logic [BW-1:0]   bit_idx;
  logic [NBIT-1:0] din;
  logic [NBIT-1:0] rdata;
  logic [1:0]      ack;
  logic            cs, busy;

`ifdef SPI_READ_SCHED_RR_EN
  assign gnt = (bus.req == 2'b11) ? ~last : ~bus.req[0];
`else
  assign gnt = ~bus.req[0];
`endif

  assign load     = (state == IDLE) && (bus.req != 2'b00);
  assign shifting = (state == ADDR) || (state == DATA);

  // address bits go out first, the data phase keeps mosi high
  spi_shift_engine #(.W(W), .RW(NBIT), .DIV(DIV), .BW(BW)) u_eng (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .en      (shifting),
    .dout    ({bus.adr[gnt], {NBIT{1'b1}}}),
    .miso    (bus.miso),
    .sclk    (eng_sclk),
    .mosi    (eng_mosi),
    .bit_end (bit_end),
    .done    (done),
    .bit_idx (bit_idx),
    .din     (din)
  );

  // state register and per-state cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= (nxt != state) ? 16'd0 : cnt + 16'd1;
    end
  end

  // grant pointer and read data, the latter updated on entry to GAP (cs rise)
  always_ff @(posedge clk) begin
    if (rst) begin
      last  <= 1'b1;
      rdata <= '0;
    end else begin
      if (load) last <= gnt;
      if (state == HOLD && nxt == GAP) rdata <= din;
    end
  end

  // next state and control outputs
  always_comb begin
    nxt  = state;
    ack  = 2'b00;
    cs   = 1'b0;
    busy = 1'b1;
    case (state)
      IDLE: begin
        cs   = 1'b1;
        busy = 1'b0;
        if (bus.req != 2'b00) nxt = SETUP;
      end
      SETUP: if (cnt == 16'(CS_SETUP - 1)) nxt = ADDR;
      ADDR:  if (bit_end && bit_idx == BW'(ABIT - 1)) nxt = DATA;
      DATA:  if (done) nxt = HOLD;
      HOLD:  if (cnt == 16'(CS_HOLD - 1)) nxt = GAP;
      GAP: begin
        // cs-rise cycle carries the ack, then CS_GAP more cycles of gap
        cs = 1'b1;
        if (cnt == 16'd0) ack[last] = 1'b1;
        if (cnt == 16'(CS_GAP)) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign bus.sclk  = eng_sclk;
  assign bus.mosi  = (state == SETUP || shifting) ? eng_mosi : 1'b1;
  assign bus.cs    = cs;
  assign bus.ack   = ack;
  assign bus.busy  = busy;
  assign bus.rdata = rdata;
endmodule
